// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and helpers for the sequential restoring
//                divider (seq_nbit_divider and its div_step datapath).
//                - div_state_t : controller state encoding
//                - ctr_width() : width of the iteration counter for width n
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    // The counter walks N-1 down to 0. It is never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division step.
//                Shifts the next dividend bit into the partial remainder,
//                trial-subtracts the divisor, and either keeps the
//                difference (quotient bit 1) or restores (quotient bit 0).
//  Ports       : i_r      - partial remainder (N bits)
//                i_q      - dividend/quotient shift register (N bits)
//                i_d      - divisor (N bits)
//                o_r_next - partial remainder after this step (N bits)
//                o_q_next - shift register after this step (N bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_r,
    input  logic [N-1:0] i_q,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_r_next,
    output logic [N-1:0] o_q_next
);

    // The partial remainder is always strictly less than the divisor, so its
    // N+1'th bit is zero at every step boundary and is not carried between
    // steps; only the trial subtraction needs the full N+1 bits.
    logic [N:0] w_shift;
    logic [N:0] w_trial;

    assign w_shift = {i_r, i_q[N-1]};
    assign w_trial = w_shift - {1'b0, i_d};

    always_comb begin
        if (w_trial[N] == 1'b0) begin
            o_r_next = w_trial[N-1:0];
            o_q_next = {i_q[N-2:0], 1'b1};
        end else begin
            // Restore: w_shift < divisor here, so its top bit is zero.
            o_r_next = w_shift[N-1:0];
            o_q_next = {i_q[N-2:0], 1'b0};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/seq_nbit_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_nbit_divider
//  Description : Sequential unsigned N-bit restoring divider, one quotient
//                bit per clock, with a start/busy/done handshake.
//                Nonzero divisor: result after N RUN cycles (done at t+N+1).
//                Zero divisor   : done at t+1, quotient all ones,
//                                 remainder = dividend, div_by_zero set.
//  Ports       : clk           - clock, rising edge
//                rst_n         - asynchronous active-low reset
//                i_start       - request, accepted whenever not busy
//                i_dividend    - unsigned dividend, sampled on accept
//                i_divisor     - unsigned divisor, sampled on accept
//                o_busy        - high during the RUN iterations
//                o_done        - one-cycle result-valid pulse
//                o_quotient    - quotient, held until the next result
//                o_remainder   - remainder, held until the next result
//                o_div_by_zero - set with the result of a zero divide
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_nbit_divider
    import div_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int CTR_W = ctr_width(N);
    localparam logic [CTR_W-1:0] C_CTR_LAST = CTR_W'(N - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;

    logic [CTR_W-1:0] r_ctr;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_d;
    logic [N-1:0]     r_r;
    logic [N-1:0]     r_quotient;
    logic [N-1:0]     r_remainder;
    logic             r_dbz;

    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_div_zero;
    logic [N-1:0]     w_r_next;
    logic [N-1:0]     w_q_next;

    // A request is taken in IDLE and also in DONE, which allows
    // back-to-back operations without an idle gap.
    assign w_accept   = i_start && (r_state != S_RUN);
    assign w_div_zero = (i_divisor == '0);

    // ------------------------------------------------------------------
    // Restoring step datapath
    // ------------------------------------------------------------------
    div_step #(
        .N (N)
    ) u_step (
        .i_r      (r_r),
        .i_q      (r_q),
        .i_d      (r_d),
        .o_r_next (w_r_next),
        .o_q_next (w_q_next)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state_next = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_ctr == '0) begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, iteration and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            r_q   <= i_dividend;
            r_d   <= i_divisor;
            r_r   <= '0;
            r_dbz <= 1'b0;
            if (w_div_zero) begin
                // Zero divide bypasses iteration; result is ready next cycle.
                r_quotient  <= '1;
                r_remainder <= i_dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_ctr <= C_CTR_LAST;
            end
        end else if (r_state == S_RUN) begin
            r_q <= w_q_next;
            r_r <= w_r_next;
            if (r_ctr == '0) begin
                // Final step: publish straight from the step outputs so the
                // result is visible in the DONE cycle.
                r_quotient  <= w_q_next;
                r_remainder <= w_r_next;
            end else begin
                r_ctr <= r_ctr - CTR_W'(1);
            end
        end
    end

    assign o_busy        = w_busy;
    assign o_done        = w_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_dbz;

endmodule : seq_nbit_divider
`default_nettype wire
